// File: rtl/csq_pkg.sv
// csq_pkg: shared types, default constants and helpers for current_sense_qualifier.
// Optional feature macro: CSQ_FAST_TRIP_EN (single-sample overcurrent trip).
package csq_pkg;

    // Short-circuit qualifier FSM states, also exported for debug.
    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        COUNTING = 2'd1,
        TRIPPED  = 2'd2
    } short_state_e;

    localparam int CSQ_W           = 12;
    localparam int CSQ_HYST        = 16;
    localparam int CSQ_SIGN_DEB    = 4;
    localparam int CSQ_SHORT_LIMIT = 1800;
    localparam int CSQ_SHORT_CNT   = 2;
`ifdef CSQ_FAST_TRIP_EN
    localparam int CSQ_FAST_LIMIT  = 2000;
`endif

    // Working width for the magnitude helper; callers sign-extend into it and
    // cast the result back down to their sample width W.
    localparam int CSQ_MAG_W = 32;

    // Absolute value of a sign-extended sample. The most negative W-bit value
    // -2^(W-1) yields +2^(W-1), which still fits a W-bit unsigned result.
    function automatic logic [CSQ_MAG_W-1:0] csq_mag(input logic signed [CSQ_MAG_W-1:0] s);
        return (s < 0) ? CSQ_MAG_W'(-s) : CSQ_MAG_W'(s);
    endfunction

endpackage

// File: rtl/current_sense_qualifier_if.sv
// current_sense_qualifier_if: sample stream in, qualified sign/short flags out.
// Handshake: sample is consumed on every cycle where sample_valid is 1; there is
// no ready/backpressure, so the source may present a new sample every cycle.
interface current_sense_qualifier_if #(
    parameter int W = 12
);
    logic         sample_valid;
    logic [W-1:0] sample;
    logic         short_clr;
    logic         curr_sign;
    logic         sign_change;
    logic         short;
    logic [1:0]   short_state;

    // Sample source / downstream FSM side.
    modport master (
        output sample_valid, sample, short_clr,
        input  curr_sign, sign_change, short, short_state
    );

    // Qualifier side.
    modport slave (
        input  sample_valid, sample, short_clr,
        output curr_sign, sign_change, short, short_state
    );
endinterface

// File: rtl/csq_run_counter.sv
// csq_run_counter: saturating run-length counter with inc / clear / hold.
// hit flags that the increment applied this cycle reaches LIMIT. With
// CLR_AT_LIMIT set, the counter restarts from zero on that hit instead of
// sitting at LIMIT. clr has priority over inc; neither asserted means hold.
module csq_run_counter #(
    parameter int LIMIT        = 4,
    parameter bit CLR_AT_LIMIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign hit = inc && (count_q >= CW'(LIMIT - 1));

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr || (CLR_AT_LIMIT && hit)) begin
            count_d = '0;
        end else if (inc && (count_q < CW'(LIMIT))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/current_sense_qualifier.sv
// current_sense_qualifier: turns the signed load-current sample stream into a
// debounced polarity (curr_sign, with a dead band around zero) and a latched
// overcurrent flag (short) for the load-switching FSM. Two register stages:
// stage 1 captures per-sample flags, stage 2 holds the qualified outputs.
// Optional feature macro: CSQ_FAST_TRIP_EN adds a single-sample trip at
// FAST_LIMIT on top of the SHORT_CNT consecutive-sample trip.
module current_sense_qualifier
    import csq_pkg::*;
#(
    parameter int W           = CSQ_W,
    parameter int HYST        = CSQ_HYST,
    parameter int SIGN_DEB    = CSQ_SIGN_DEB,
    parameter int SHORT_LIMIT = CSQ_SHORT_LIMIT,
    parameter int SHORT_CNT   = CSQ_SHORT_CNT
`ifdef CSQ_FAST_TRIP_EN
    ,
    parameter int FAST_LIMIT  = CSQ_FAST_LIMIT
`endif
) (
    input logic                        clk,
    input logic                        rst,
    current_sense_qualifier_if.slave   bus
);

    // ---------------- stage 1: per-sample flags ----------------
    logic signed [CSQ_MAG_W-1:0] samp_ext;
    logic [W-1:0]                mag;

    assign samp_ext = {{(CSQ_MAG_W - W){bus.sample[W-1]}}, bus.sample};
    assign mag      = W'(csq_mag(samp_ext));

    logic v1_q, v1_d;
    logic pos_q, pos_d;
    logic neg_q, neg_d;
    logic over_q, over_d;
`ifdef CSQ_FAST_TRIP_EN
    logic fast_q, fast_d;
`endif

    // Flags are qualified by sample_valid so an empty stage never reads as over/pos/neg.
    always_comb begin
        v1_d   = bus.sample_valid;
        pos_d  = bus.sample_valid && (samp_ext > HYST);
        neg_d  = bus.sample_valid && (samp_ext < -HYST);
        over_d = bus.sample_valid && ({{(CSQ_MAG_W - W){1'b0}}, mag} >= SHORT_LIMIT);
`ifdef CSQ_FAST_TRIP_EN
        fast_d = bus.sample_valid && ({{(CSQ_MAG_W - W){1'b0}}, mag} >= FAST_LIMIT);
`endif
    end

    // Stage-1 registers; reset drops any in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
            over_q <= 1'b0;
`ifdef CSQ_FAST_TRIP_EN
            fast_q <= 1'b0;
`endif
        end else begin
            v1_q   <= v1_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
            over_q <= over_d;
`ifdef CSQ_FAST_TRIP_EN
            fast_q <= fast_d;
`endif
        end
    end

    // ---------------- sign qualifier ----------------
    logic curr_sign_q, curr_sign_d;
    logic sign_change_q, sign_change_d;
    logic opposing;
    logic agreeing;
    logic run_hit;

    // In-band samples assert neither, so the run simply holds across them.
    assign opposing = v1_q && (curr_sign_q ? neg_q : pos_q);
    assign agreeing = v1_q && (curr_sign_q ? pos_q : neg_q);

    csq_run_counter #(
        .LIMIT        (SIGN_DEB),
        .CLR_AT_LIMIT (1'b1)
    ) u_sign_run (
        .clk (clk),
        .rst (rst),
        .inc (opposing),
        .clr (agreeing),
        .hit (run_hit)
    );

    // Flip polarity and pulse sign_change when the opposing run completes.
    always_comb begin
        curr_sign_d   = curr_sign_q;
        sign_change_d = 1'b0;
        if (run_hit) begin
            curr_sign_d   = ~curr_sign_q;
            sign_change_d = 1'b1;
        end
    end

    // Sign output registers; polarity resets to positive.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_sign_q   <= 1'b1;
            sign_change_q <= 1'b0;
        end else begin
            curr_sign_q   <= curr_sign_d;
            sign_change_q <= sign_change_d;
        end
    end

    // ---------------- short FSM ----------------
    short_state_e state_q, state_d;
    logic         short_q, short_d;
    logic         ocnt_inc;
    logic         ocnt_clr;
    logic         ocnt_hit;
    logic         clr_ok;

    // A clear is only honoured when the stage-1 sample is not itself over limit.
    assign clr_ok   = bus.short_clr && !over_q;
    // Counter controls depend only on registered state so the FSM can read hit freely.
    assign ocnt_inc = v1_q && over_q && (state_q != TRIPPED);
    assign ocnt_clr = ((state_q == COUNTING) && v1_q && !over_q) ||
                      ((state_q == TRIPPED) && clr_ok);

    csq_run_counter #(
        .LIMIT        (SHORT_CNT),
        .CLR_AT_LIMIT (1'b0)
    ) u_over_run (
        .clk (clk),
        .rst (rst),
        .inc (ocnt_inc),
        .clr (ocnt_clr),
        .hit (ocnt_hit)
    );

    // Next state: arm, count consecutive over samples, latch trip until cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED: begin
                if (v1_q && over_q) begin
                    state_d = ocnt_hit ? TRIPPED : COUNTING;
                end
            end
            COUNTING: begin
                if (v1_q) begin
                    if (!over_q) begin
                        state_d = ARMED;
                    end else if (ocnt_hit) begin
                        state_d = TRIPPED;
                    end
                end
            end
            TRIPPED: begin
                if (clr_ok) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
`ifdef CSQ_FAST_TRIP_EN
        if (v1_q && fast_q && (state_q != TRIPPED)) begin
            state_d = TRIPPED;
        end
`endif
        short_d = (state_d == TRIPPED);
    end

    // FSM state and registered short decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARMED;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            short_q <= short_d;
        end
    end

    assign bus.curr_sign   = curr_sign_q;
    assign bus.sign_change = sign_change_q;
    assign bus.short       = short_q;
    assign bus.short_state = state_q;

endmodule

// File: tb/tb_current_sense_qualifier.sv
// tb_current_sense_qualifier: table vectors, directed corner sequences and
// randomized traffic for current_sense_qualifier, checked against a
// behavioural model of the qualifier rules.
module tb_current_sense_qualifier;
    localparam int W           = 12;
    localparam int HYST        = 16;
    localparam int SIGN_DEB    = 4;
    localparam int SHORT_LIMIT = 1800;
    localparam int SHORT_CNT   = 2;
`ifdef CSQ_FAST_TRIP_EN
    localparam int FAST_LIMIT  = 2000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    current_sense_qualifier_if #(.W(W)) bus ();

    current_sense_qualifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bit   m_sign;
    bit   m_chg;
    bit   m_trip;
    int   m_run;
    int   m_ocount;
    bit   st_v;
    int   st_s;
    logic [4:0] exp_q[$];

    // One clock edge of the qualifier rules, using the sample captured on the previous edge.
    task automatic model_edge(input bit v, input int s, input bit clr, input bit r);
        int a;
        bit p;
        bit n;
        bit ov;
        logic [1:0] st;
        if (r) begin
            m_sign = 1'b1; m_chg = 1'b0; m_trip = 1'b0;
            m_run = 0; m_ocount = 0; st_v = 1'b0; st_s = 0;
        end else begin
            m_chg = 1'b0;
            a  = (st_s < 0) ? -st_s : st_s;
            p  = st_v && (st_s > HYST);
            n  = st_v && (st_s < -HYST);
            ov = st_v && (a >= SHORT_LIMIT);
            if ((p && !m_sign) || (n && m_sign)) begin
                m_run++;
                if (m_run == SIGN_DEB) begin
                    m_sign = !m_sign;
                    m_run  = 0;
                    m_chg  = 1'b1;
                end
            end else if (p || n) begin
                m_run = 0;
            end
            if (m_trip) begin
                if (clr && !ov) begin
                    m_trip = 1'b0;
                    m_ocount = 0;
                end
            end else if (st_v) begin
                if (ov) begin
                    m_ocount++;
                    if (m_ocount >= SHORT_CNT) m_trip = 1'b1;
                end else begin
                    m_ocount = 0;
                end
`ifdef CSQ_FAST_TRIP_EN
                if (a >= FAST_LIMIT) m_trip = 1'b1;
`endif
            end
            st_v = v;
            st_s = s;
        end
        st = m_trip ? 2'd2 : ((m_ocount > 0) ? 2'd1 : 2'd0);
        exp_q.push_back({m_sign, m_chg, m_trip, st});
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_model(input string name);
        logic [4:0] exp;
        logic [4:0] act;
        act = {bus.curr_sign, bus.sign_change, bus.short, bus.short_state};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expected entry, got %b", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_errors++;
                $display("FAIL %s @%0t: got sign=%b chg=%b short=%b state=%0d, expected sign=%b chg=%b short=%b state=%0d",
                         name, $time, act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit v, input int s, input bit clr, input bit r, input string name);
        bus.sample_valid = v;
        bus.sample       = W'(s);
        bus.short_clr    = clr;
        rst              = r;
        @(posedge clk);
        #1;
        model_edge(v, s, clr, r);
        compare_model(name);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         v;
        int         s;
        bit         clr;
        bit         e_sign;
        bit         e_chg;
        bit         e_short;
        logic [1:0] e_state;
    } vec_t;

    function automatic vec_t mk(input bit v, input int s, input bit clr,
                                input bit es, input bit ec, input bit esh, input logic [1:0] est);
        vec_t t;
        t.v = v; t.s = s; t.clr = clr;
        t.e_sign = es; t.e_chg = ec; t.e_short = esh; t.e_state = est;
        return t;
    endfunction

    task automatic check_vec(input string name, input vec_t t);
        logic [4:0] exp;
        logic [4:0] act;
        exp = {t.e_sign, t.e_chg, t.e_short, t.e_state};
        act = {bus.curr_sign, bus.sign_change, bus.short, bus.short_state};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (sign,chg,short,state)", name, act, exp);
        end
    endtask

    vec_t tbl[16];

    initial begin
        bit pol;
        int mg;
        int s;
        bit v;

        // Each row: inputs for one cycle, outputs expected right after that edge.
        tbl[0]  = mk(1, -100, 0, 1, 0, 0, 2'd0);
        tbl[1]  = mk(1, -100, 0, 1, 0, 0, 2'd0);
        tbl[2]  = mk(1, -100, 0, 1, 0, 0, 2'd0);
        tbl[3]  = mk(1, -100, 0, 1, 0, 0, 2'd0);
        tbl[4]  = mk(0,    0, 0, 0, 1, 0, 2'd0);
        tbl[5]  = mk(0,    0, 0, 0, 0, 0, 2'd0);
        tbl[6]  = mk(1,   10, 0, 0, 0, 0, 2'd0);
        tbl[7]  = mk(1,  -10, 0, 0, 0, 0, 2'd0);
        tbl[8]  = mk(1, 1900, 0, 0, 0, 0, 2'd0);
        tbl[9]  = mk(1,    0, 0, 0, 0, 0, 2'd1);
        tbl[10] = mk(1, 1900, 0, 0, 0, 0, 2'd0);
        tbl[11] = mk(1, 1900, 0, 0, 0, 0, 2'd1);
        tbl[12] = mk(0,    0, 0, 0, 0, 1, 2'd2);
        tbl[13] = mk(1,  100, 0, 0, 0, 1, 2'd2);
        tbl[14] = mk(0,    0, 0, 1, 1, 1, 2'd2);
        tbl[15] = mk(0,    0, 1, 1, 0, 0, 2'd0);

        // Reset: three cycles, no samples.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "reset");
        check_bit("reset_sign", bus.curr_sign, 1'b1);
        check_bit("reset_short", bus.short, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].clr, 0, "table_model");
            check_vec($sformatf("table_row%0d", i), tbl[i]);
        end

        // Agreeing sample in the middle of an opposing run restarts the debounce.
        for (int i = 0; i < 3; i++) step(1, -100, 0, 0, "agree_run");
        step(1, 100, 0, 0, "agree_run");
        for (int i = 0; i < 3; i++) step(1, -100, 0, 0, "agree_run");
        step(0, 0, 0, 0, "agree_run");
        check_bit("noflip_after_agree", bus.curr_sign, 1'b1);
        step(1, -100, 0, 0, "agree_run");
        step(0, 0, 0, 0, "agree_run");
        check_bit("flip_after_four", bus.curr_sign, 1'b0);
        check_bit("flip_pulse", bus.sign_change, 1'b1);

        // Hysteresis: in-band chatter never moves the sign.
        for (int i = 0; i < 20; i++) step(1, (i % 2) ? -10 : 10, 0, 0, "hyst");
        step(0, 0, 0, 0, "hyst");
        check_bit("hyst_hold", bus.curr_sign, 1'b0);
        step(1, -100, 0, 0, "hyst");
        step(1, 12, 0, 0, "hyst");
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0, "hyst");
        check_bit("hyst_before_fourth", bus.curr_sign, 1'b0);
        step(0, 0, 0, 0, "hyst");
        check_bit("hyst_flip", bus.curr_sign, 1'b1);
        check_bit("hyst_flip_pulse", bus.sign_change, 1'b1);

        // Trip, clear blocked by a concurrent over sample, then accepted clear.
        step(1, 1900, 0, 0, "short");
        step(1, 1900, 0, 0, "short");
        step(0, 0, 0, 0, "short");
        check_bit("trip_two", bus.short, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 1900, 1, 0, "short_clr");
        check_bit("clr_blocked", bus.short, 1'b1);
        step(1, 0, 1, 0, "short_clr");
        check_bit("clr_blocked_last", bus.short, 1'b1);
        step(0, 0, 1, 0, "short_clr");
        check_bit("clr_accepted", bus.short, 1'b0);
        step(0, 0, 0, 0, "short_clr");

        // Most negative sample, back to back.
        step(1, -2048, 0, 0, "extreme");
        step(1, -2048, 0, 0, "extreme");
        step(1, -2048, 0, 0, "extreme");
        check_bit("extreme_trip", bus.short, 1'b1);
        step(1, -2048, 0, 0, "extreme");
        check_bit("extreme_sign_hold", bus.curr_sign, 1'b1);
        step(0, 0, 0, 0, "extreme");
        check_bit("extreme_sign", bus.curr_sign, 1'b0);
        step(0, 0, 1, 0, "extreme");
        step(0, 0, 0, 0, "extreme");

        // Single large sample.
        step(1, 2047, 0, 0, "fast");
        step(0, 0, 0, 0, "fast");
`ifdef CSQ_FAST_TRIP_EN
        check_bit("fast_trip", bus.short, 1'b1);
`else
        check_bit("fast_no_trip", bus.short, 1'b0);
`endif
        step(0, 0, 1, 0, "fast");
        step(0, 0, 0, 0, "fast");

        // Reset between the third and fourth opposing sample.
        step(0, 0, 0, 1, "rst_mid");
        for (int i = 0; i < 3; i++) step(1, -100, 0, 0, "rst_mid");
        step(1, -100, 0, 1, "rst_mid");
        for (int i = 0; i < 3; i++) step(1, -100, 0, 0, "rst_mid");
        step(0, 0, 0, 0, "rst_mid");
        check_bit("rst_noflip", bus.curr_sign, 1'b1);
        step(1, -100, 0, 0, "rst_mid");
        step(0, 0, 0, 0, "rst_mid");
        check_bit("rst_restart_flip", bus.curr_sign, 1'b0);

        // Randomized traffic with polarity phases and sporadic clears/resets.
        pol = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ((i % 12) == 0) pol = !pol;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       mg = int'($urandom_range(0, 30));
                1:       mg = int'($urandom_range(0, 300));
                2:       mg = int'($urandom_range(1700, 2048));
                default: mg = int'($urandom_range(0, 2048));
            endcase
            if ($urandom_range(0, 4) == 0) s = pol ? -mg : mg;
            else                            s = pol ? mg : -mg;
            if (s > 2047) s = 2047;
            step(v, s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0), "random");
        end
        step(0, 0, 0, 0, "drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/current_sense_qualifier.md
# current_sense_qualifier

- Upstream stage of the load-switching FSM.
- Converts the signed load-current ADC sample stream into the two qualified control inputs the FSM consumes:
  - `curr_sign`, a debounced current polarity with a hysteresis band around zero.
  - `short`, a latched overcurrent trip.
- Outputs are registered so the FSM's commutation choice never sees a noisy or glitching sign.

## Interface
- `W`, 12: ADC sample width, two's complement.
- `HYST`, 16: half-width of the zero band. Samples with |s| ≤ HYST carry no sign information.
- `SIGN_DEB`, 4: number of consecutive opposing out-of-band samples needed to flip `curr_sign`.
- `SHORT_LIMIT`, 1800: magnitude threshold for overcurrent.
- `SHORT_CNT`, 2: number of consecutive samples with magnitude ≥ SHORT_LIMIT needed to trip.
- `FAST_LIMIT`, 2000: single-sample trip threshold. Used only with CSQ_FAST_TRIP_EN.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `sample_valid`, in, 1: `sample` is valid this cycle. There is no backpressure; every valid sample is consumed.
- `sample`, in, W: signed current sample.
- `short_clr`, in, 1: request to release a latched short.
- `curr_sign`, out, 1: 1 means positive current, 0 means negative.
- `sign_change`, out, 1: one-cycle pulse on every `curr_sign` flip.
- `short`, out, 1: latched overcurrent flag, fed to the FSM's Short input.
- `short_state`, out, 2: encoded short-FSM state, for debug.

## Operation
- **Stage 1 (capture edge of a valid sample):**
  - `mag` = |sample|, held as W-bit unsigned. -2^(W-1) maps to 2^(W-1), so no saturation is needed.
  - Registered flags:
    - `pos` = sample > HYST.
    - `neg` = sample < -HYST.
    - `over` = mag ≥ SHORT_LIMIT.
    - `fast` = mag ≥ FAST_LIMIT.
  - `v1` registers `sample_valid`.
- **Sign qualifier (acts when v1 = 1):**
  - Opposing sample (`pos` while `curr_sign` = 0, or `neg` while `curr_sign` = 1): `run` increments.
  - When `run` reaches SIGN_DEB: `curr_sign` toggles, `run` clears to 0, and `sign_change` pulses.
  - Agreeing out-of-band sample: `run` clears to 0.
  - In-band sample (neither `pos` nor `neg`): `run` holds.
  - `run` width is clog2(SIGN_DEB+1). It saturates and never wraps.
- **Short FSM states:** ARMED = 0, COUNTING = 1, TRIPPED = 2.
  - ARMED, valid `over`: `ocnt` ← 1. If SHORT_CNT = 1, go to TRIPPED; otherwise go to COUNTING.
  - COUNTING, valid `over`: `ocnt`++. At SHORT_CNT, go to TRIPPED.
  - COUNTING, valid with no `over`: `ocnt` ← 0, go to ARMED.
  - COUNTING, invalid cycle: hold.
  - TRIPPED: `short` = 1. Leave only on `short_clr` = 1 when the stage-1 `over` flag is 0; then go to ARMED with `ocnt` = 0.
  - TRIPPED with `short_clr` and `over` in the same cycle: stay TRIPPED. The trip wins.
  - `short` is a registered decode of TRIPPED.
- The sign qualifier keeps running while TRIPPED, so the FSM has the correct polarity on recovery.
- **Reset values:** `curr_sign` = 1, `sign_change` = 0, `short` = 0, `short_state` = ARMED.
  - Internal state also resets: `run` = 0, `ocnt` = 0, `v1` = 0.
  - Reset mid-operation discards any in-flight stage-1 sample.

## Timing
- A sample captured at edge N reaches registered outputs at edge N+1. Latency is 2 edges from the sample cycle.
- Fully pipelined: back-to-back valid samples every cycle are supported.
- Best-case sign flip: SIGN_DEB consecutive opposing samples, with the flip visible 1 edge after the last one is captured.
- Trip: SHORT_CNT consecutive valid `over` samples. Invalid cycles between them do not break the run.
- `short_clr` is sampled every cycle. `short` falls at the edge following the accepted clear.
- `sign_change` is high for exactly one cycle per flip. Flips are never closer than SIGN_DEB valid samples apart.

## Configuration
- **CSQ_FAST_TRIP_EN defined:**
  - A single valid `fast` sample sends ARMED or COUNTING straight to TRIPPED.
  - `short` rises at edge N+1 regardless of `ocnt`.
- **CSQ_FAST_TRIP_EN not defined:**
  - The `fast` flag and FAST_LIMIT are removed from the logic.
  - Only the SHORT_CNT run can trip.

## Structure
- Package `csq_pkg` holds:
  - the short-FSM state enum (ARMED, COUNTING, TRIPPED);
  - the default parameter constants;
  - the W-bit magnitude function.
- Sub-module `csq_run_counter` is a saturating counter with inc, clear and hold controls and a `hit` output at a parameter limit.
  - Instantiated twice: for the sign `run` and for `ocnt`.

## Test plan
- **Reset:** `rst` for 3 cycles, no samples → `curr_sign` = 1, `short` = 0, `short_state` = 0, `sign_change` = 0.
- **Sign flip:** 4 consecutive valid samples of -100 → `curr_sign` falls 1 edge after the 4th and `sign_change` pulses once. 3 samples of -100 then +100 → no flip.
- **Hysteresis:** alternating ±10 for 20 cycles after `curr_sign` = 0 → no flip and `run` unchanged. Then -100, +12, +100×4 → flip to 1 on the 4th +100.
- **Short trip and clear:**
  - 1900, 0, 1900, 1900 → `short` rises 1 edge after the 2nd consecutive 1900.
  - `short_clr` together with a 1900 sample → stays 1.
  - `short_clr` with a 0 sample → falls.
- **Extreme and back-to-back:** -2048 every cycle for 2 cycles → magnitude is 2048, trips. `curr_sign` goes to 0 after 4 samples.
- **Fast trip and reset mid-run:**
  - With CSQ_FAST_TRIP_EN, a single 2047 → `short` at edge N+1. Without the macro → no trip.
  - `rst` asserted between the 3rd and 4th opposing sample → no flip, counter restarts.
